// File: rtl/sound_mixer_ng_if.sv
// Sample stream, result and register-port signals of sound_mixer_ng.
// master = sound sources / CPU side, slave = the mixer.
interface sound_mixer_ng_if #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned GAIN_WIDTH = 8
);
  logic                         SAMPLE_EN;
  logic [CHANNELS*IN_WIDTH-1:0] IN_DATA;
  logic                         REG_WR;
  logic [3:0]                   REG_ADDR;
  logic [GAIN_WIDTH-1:0]        REG_WDATA;
  logic [GAIN_WIDTH-1:0]        REG_RDATA;
  logic [OUT_WIDTH-1:0]         OUT_DATA;
  logic                         OUT_VALID;
  logic                         BUSY;
  logic                         CLIP;
  logic                         OVERRUN;

  modport master (
    output SAMPLE_EN, IN_DATA, REG_WR, REG_ADDR, REG_WDATA,
    input  REG_RDATA, OUT_DATA, OUT_VALID, BUSY, CLIP, OVERRUN
  );

  modport slave (
    input  SAMPLE_EN, IN_DATA, REG_WR, REG_ADDR, REG_WDATA,
    output REG_RDATA, OUT_DATA, OUT_VALID, BUSY, CLIP, OVERRUN
  );
endinterface

// File: rtl/sound_mixer_ng.sv
// Time-multiplexed MAC mixer: run-time gains, saturation to OUT_WIDTH, sticky CLIP/OVERRUN.
// Define SOUND_MIXER_NG_FADE_EN to make effective gains step by 1 toward their targets per sample.
module sound_mixer_ng #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned GAIN_WIDTH = 8,
  parameter int unsigned GAIN_RESET = 128
) (
  input logic             CLK,
  input logic             RESET_n,
  sound_mixer_ng_if.slave bus
);

  localparam int unsigned ACC_W  = IN_WIDTH + GAIN_WIDTH + $clog2(CHANNELS) + 1;
  localparam int unsigned PROD_W = IN_WIDTH + GAIN_WIDTH + 1;
  localparam logic [GAIN_WIDTH-1:0] GAIN_INIT   = GAIN_WIDTH'(GAIN_RESET);
  localparam logic [3:0]            LAST_CH     = 4'(CHANNELS - 1);
  localparam logic [3:0]            STATUS_ADDR = 4'd15;
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

  state_t                       state, state_next;
  logic                         busy;
  logic [GAIN_WIDTH-1:0]        gain_reg  [CHANNELS];
  logic [GAIN_WIDTH-1:0]        gain_src  [CHANNELS];
  logic signed [IN_WIDTH-1:0]   snap_in   [CHANNELS];
  logic [GAIN_WIDTH-1:0]        snap_gain [CHANNELS];
  logic signed [ACC_W-1:0]      acc;
  logic [3:0]                   ch;
  logic signed [IN_WIDTH-1:0]   cur_in;
  logic [GAIN_WIDTH-1:0]        cur_gain;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      shifted;
  logic [OUT_WIDTH-1:0]         sat;
  logic                         sat_hit;
  logic [OUT_WIDTH-1:0]         out_data;
  logic                         out_valid;
  logic                         clip, overrun;
  logic                         accept, status_wr;

  assign accept    = (state == IDLE) && bus.SAMPLE_EN;
  assign status_wr = bus.REG_WR && (bus.REG_ADDR == STATUS_ADDR);

`ifdef SOUND_MIXER_NG_FADE_EN
  logic [GAIN_WIDTH-1:0] gain_eff [CHANNELS];

  // The stepped value is what gets snapshotted, so the step lands before the mix.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      gain_src[i] = gain_eff[i];
      if (gain_eff[i] < gain_reg[i])      gain_src[i] = gain_eff[i] + 1'b1;
      else if (gain_eff[i] > gain_reg[i]) gain_src[i] = gain_eff[i] - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) gain_eff[i] <= GAIN_INIT;
    end else if (accept) begin
      for (int unsigned i = 0; i < CHANNELS; i++) gain_eff[i] <= gain_src[i];
    end
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) gain_src[i] = gain_reg[i];
  end
`endif

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.SAMPLE_EN) state_next = ACCUM;
      end
      ACCUM:   if (ch == LAST_CH) state_next = SCALE;
      SCALE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cur_in   = '0;
    cur_gain = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (ch == 4'(i)) begin
        cur_in   = snap_in[i];
        cur_gain = snap_gain[i];
      end
    end
  end

  assign prod = cur_in * $signed({1'b0, cur_gain});

  always_comb begin
    shifted = acc >>> (GAIN_WIDTH - 1);
    sat     = shifted[OUT_WIDTH-1:0];
    sat_hit = 1'b0;
    if (shifted > OUT_MAX) begin
      sat     = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      sat_hit = 1'b1;
    end else if (shifted < OUT_MIN) begin
      sat     = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      acc       <= '0;
      ch        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        snap_in[i]   <= '0;
        snap_gain[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: if (bus.SAMPLE_EN) begin
          acc <= '0;
          ch  <= '0;
          for (int unsigned i = 0; i < CHANNELS; i++) begin
            snap_in[i]   <= bus.IN_DATA[i*IN_WIDTH +: IN_WIDTH];
            snap_gain[i] <= gain_src[i];
          end
        end
        ACCUM: begin
          acc <= acc + ACC_W'(prod);
          ch  <= ch + 4'd1;
        end
        SCALE: begin
          out_data  <= sat;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Set events are applied after clears so a coincident set wins.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) gain_reg[i] <= GAIN_INIT;
      clip    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (bus.REG_WR) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (bus.REG_ADDR == 4'(i)) gain_reg[i] <= bus.REG_WDATA;
        end
      end
      if (status_wr && bus.REG_WDATA[0]) clip    <= 1'b0;
      if (status_wr && bus.REG_WDATA[1]) overrun <= 1'b0;
      if (state == SCALE && sat_hit)     clip    <= 1'b1;
      if (bus.SAMPLE_EN && busy)         overrun <= 1'b1;
    end
  end

  always_comb begin
    bus.REG_RDATA = '0;
    if (bus.REG_ADDR == STATUS_ADDR) begin
      bus.REG_RDATA = GAIN_WIDTH'({overrun, clip});
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (bus.REG_ADDR == 4'(i)) bus.REG_RDATA = gain_reg[i];
      end
    end
  end

  assign bus.OUT_DATA  = out_data;
  assign bus.OUT_VALID = out_valid;
  assign bus.BUSY      = busy;
  assign bus.CLIP      = clip;
  assign bus.OVERRUN   = overrun;

endmodule

// File: tb/tb_sound_mixer_ng.sv
// Self-checking bench for sound_mixer_ng (CHANNELS=4): vector table plus hand sequences,
// outputs checked against a scoreboard of expected values and due cycles.
module tb_sound_mixer_ng;

  localparam int unsigned LAT = 6;

  logic CLK = 1'b0;
  logic RESET_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  sound_mixer_ng_if #(.CHANNELS(4), .IN_WIDTH(16), .OUT_WIDTH(16), .GAIN_WIDTH(8)) bus ();

  sound_mixer_ng #(
    .CHANNELS(4), .IN_WIDTH(16), .OUT_WIDTH(16), .GAIN_WIDTH(8), .GAIN_RESET(128)
  ) dut (
    .CLK(CLK),
    .RESET_n(RESET_n),
    .bus(bus)
  );

  typedef struct {
    int data;
    int due;
    bit chk;
  } sb_t;
  sb_t sb[$];
  sb_t mon_e;

  typedef struct {
    logic [3:0][7:0] g;
    logic [63:0]     x;
    int              exp_out;
    bit              exp_clip;
    bit              clr;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  always @(negedge CLK) begin
    if (RESET_n && bus.OUT_VALID) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk) check("out_data", int'($signed(bus.OUT_DATA)), mon_e.data);
        check("latency", cyc, mon_e.due);
      end
    end
  end

  // Caller is at a negedge; strobe lasts one cycle.
  task automatic sample(input logic [63:0] x, input bit push, input int exp, input bit chk);
    sb_t e;
    bus.IN_DATA   = x;
    bus.SAMPLE_EN = 1'b1;
    if (push) begin
      e.data = exp;
      e.due  = cyc + LAT;
      e.chk  = chk;
      sb.push_back(e);
    end
    @(negedge CLK);
    bus.SAMPLE_EN = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      check("output_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
    bus.REG_WR    = 1'b1;
    bus.REG_ADDR  = a;
    bus.REG_WDATA = d;
    @(negedge CLK);
    bus.REG_WR    = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, input string name, input int exp);
    bus.REG_ADDR = a;
    #1;
    check(name, int'(bus.REG_RDATA), exp);
  endtask

  task automatic add_vec(input logic [7:0] g0, input logic [7:0] g1, input logic [7:0] g2,
                         input logic [7:0] g3, input logic [63:0] x, input int exp_out,
                         input bit exp_clip, input bit clr);
    vec_t v;
    v.g        = {g3, g2, g1, g0};
    v.x        = x;
    v.exp_out  = exp_out;
    v.exp_clip = exp_clip;
    v.clr      = clr;
    vecs.push_back(v);
  endtask

  initial begin
    int exp;
    vec_t v;

    add_vec(8'h80, 8'h80, 8'h80, 8'h80, pk(1000, 2000, -500, 0),        2500, 1'b0, 1'b0);
    add_vec(8'h40, 8'h00, 8'h00, 8'h00, pk(1000, 0, 0, 0),               500, 1'b0, 1'b0);
    add_vec(8'h40, 8'h00, 8'h00, 8'h00, pk(-3, 0, 0, 0),                  -2, 1'b0, 1'b0);
    add_vec(8'h01, 8'h01, 8'h01, 8'h01, pk(-1, 0, 0, 0),                  -1, 1'b0, 1'b0);
    add_vec(8'h10, 8'h20, 8'h30, 8'h01, pk(100, 200, 300, -7),           174, 1'b0, 1'b0);
    add_vec(8'h80, 8'h80, 8'h80, 8'h80, pk(32767, 0, 0, 0),            32767, 1'b0, 1'b0);
    add_vec(8'h80, 8'h80, 8'h80, 8'h80, pk(-32768, 0, 0, 0),          -32768, 1'b0, 1'b0);
    add_vec(8'h80, 8'h80, 8'h80, 8'h80, pk(20000, 20000, 20000, 20000), 32767, 1'b1, 1'b0);
    add_vec(8'h80, 8'h80, 8'h80, 8'h80, pk(-20000, -20000, -20000, -20000), -32768, 1'b1, 1'b1);
    add_vec(8'hFF, 8'h00, 8'h00, 8'h00, pk(32767, 0, 0, 0),            32767, 1'b1, 1'b1);
    add_vec(8'hFF, 8'hFF, 8'hFF, 8'hFF, pk(-32768, -32768, -32768, -32768), -32768, 1'b1, 1'b1);
    add_vec(8'h80, 8'h80, 8'h80, 8'h80, pk(32767, 1, 0, 0),            32767, 1'b1, 1'b1);
    add_vec(8'h80, 8'h80, 8'h80, 8'h80, pk(0, 0, 0, 0),                    0, 1'b0, 1'b1);

    RESET_n       = 1'b0;
    bus.SAMPLE_EN = 1'b0;
    bus.IN_DATA   = '0;
    bus.REG_WR    = 1'b0;
    bus.REG_ADDR  = '0;
    bus.REG_WDATA = '0;
    repeat (3) @(negedge CLK);
    check("rst_out_data", int'(bus.OUT_DATA), 0);
    check("rst_out_valid", int'(bus.OUT_VALID), 0);
    check("rst_busy", int'(bus.BUSY), 0);
    check("rst_clip", int'(bus.CLIP), 0);
    check("rst_overrun", int'(bus.OVERRUN), 0);
    RESET_n = 1'b1;
    @(negedge CLK);

    for (int a = 0; a < 4; a++) reg_read(4'(a), "rst_gain", 128);
    reg_read(4'd15, "rst_status", 0);
    @(negedge CLK);
    reg_write(4'd5, 8'h55);
    reg_read(4'd5, "unmapped_rd5", 0);
    reg_read(4'd4, "unmapped_rd4", 0);
    @(negedge CLK);

    foreach (vecs[k]) begin
      v = vecs[k];
      for (int c = 0; c < 4; c++) reg_write(4'(c), v.g[c]);
      reg_read(4'd0, "gain0_rd", int'(v.g[0]));
      @(negedge CLK);
`ifdef SOUND_MIXER_NG_FADE_EN
      for (int s = 0; s < 255; s++) begin
        sample(v.x, 1'b1, 0, 1'b0);
        wait_done();
      end
`endif
      if (v.clr) reg_write(4'd15, 8'h01);
      sample(v.x, 1'b1, v.exp_out, 1'b1);
      wait_done();
      check("vec_clip", int'(bus.CLIP), int'(v.exp_clip));
    end

    // Overrun: second strobe two cycles in is dropped.
    reg_write(4'd15, 8'h03);
    check("ovr_cleared", int'(bus.OVERRUN), 0);
    sample(pk(1000, 2000, -500, 0), 1'b1, 2500, 1'b1);
    @(negedge CLK);
    check("busy_mid_mix", int'(bus.BUSY), 1);
    sample(pk(1, 1, 1, 1), 1'b0, 0, 1'b0);
    wait_done();
    repeat (4) @(negedge CLK);
    check("overrun_set", int'(bus.OVERRUN), 1);
    reg_read(4'd15, "status_rd", 2);

    // Strobe coincident with OUT_VALID is accepted.
    sample(pk(100, 0, 0, 0), 1'b1, 100, 1'b1);
    repeat (5) @(negedge CLK);
    check("valid_at_b2b", int'(bus.OUT_VALID), 1);
    sample(pk(0, 0, 0, -300), 1'b1, -300, 1'b1);
    wait_done();

    // Set and clear of OVERRUN in the same cycle: set wins.
    reg_write(4'd15, 8'h02);
    check("ovr_clr", int'(bus.OVERRUN), 0);
    sample(pk(10, 0, 0, 0), 1'b1, 10, 1'b1);
    bus.SAMPLE_EN = 1'b1;
    bus.REG_WR    = 1'b1;
    bus.REG_ADDR  = 4'd15;
    bus.REG_WDATA = 8'h02;
    @(negedge CLK);
    bus.SAMPLE_EN = 1'b0;
    bus.REG_WR    = 1'b0;
    wait_done();
    check("ovr_set_wins", int'(bus.OVERRUN), 1);

    // Gain write during ACCUM affects only the next sample.
    sample(pk(100, 200, 300, 400), 1'b1, 1000, 1'b1);
    @(negedge CLK);
    reg_write(4'd1, 8'h00);
    wait_done();
    reg_read(4'd1, "gain1_rd", 0);
    @(negedge CLK);
`ifdef SOUND_MIXER_NG_FADE_EN
    exp = 998;
`else
    exp = 800;
`endif
    sample(pk(100, 200, 300, 400), 1'b1, exp, 1'b1);
    wait_done();

    // Reset mid-ACCUM: mix aborted, nothing emitted.
    sample(pk(1, 1, 1, 1), 1'b0, 0, 1'b0);
    @(negedge CLK);
    RESET_n = 1'b0;
    #1;
    check("abort_out_data", int'(bus.OUT_DATA), 0);
    check("abort_out_valid", int'(bus.OUT_VALID), 0);
    check("abort_busy", int'(bus.BUSY), 0);
    check("abort_overrun", int'(bus.OVERRUN), 0);
    check("abort_clip", int'(bus.CLIP), 0);
    reg_read(4'd1, "abort_gain1", 128);
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1;
    repeat (10) @(negedge CLK);

    // Fade-out of channel 0 from 0x80 to 0.
    for (int c = 0; c < 4; c++) reg_write(4'(c), 8'h00);
    reg_read(4'd0, "fade_target_rd", 0);
    @(negedge CLK);
    for (int k = 1; k <= 130; k++) begin
`ifdef SOUND_MIXER_NG_FADE_EN
      exp = (k <= 128) ? 128 - k : 0;
`else
      exp = 0;
`endif
      sample(pk(128, 0, 0, 0), 1'b1, exp, 1'b1);
      wait_done();
    end

    repeat (4) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/sound_mixer_ng.md
Name: sound_mixer_ng

Overview:
Parametrised successor to the fixed attenuator-plus-mixer chain in the cartridge top level. It mixes CHANNELS signed sound sources using per-channel gains that software can program at run time through a small register port, instead of compile-time MUL/DIV constants. A single time-multiplexed multiply-accumulate unit processes one channel per clock, then saturates the sum to OUT_WIDTH and flags clipping and overrun. It sits between the cartridge sound sources and the external or internal sound outputs.

Parameters:
CHANNELS, 4, number of input sources; legal range 1..15.
IN_WIDTH, 16, width of each signed input sample.
OUT_WIDTH, 16, width of the signed output sample.
GAIN_WIDTH, 8, unsigned gain width in Q1.(GAIN_WIDTH-1) format; 0x80 = 1.0, 0xFF ≈ 1.99.
GAIN_RESET, 128, reset value of every gain register.

Ports:
CLK  in  1  clock
RESET_n  in  1  asynchronous active-low reset
SAMPLE_EN  in  1  one-cycle strobe: new input set is valid
IN_DATA  in  CHANNELS*IN_WIDTH  signed samples; channel n occupies bits [n*IN_WIDTH +: IN_WIDTH]
REG_WR  in  1  register write strobe
REG_ADDR  in  4  0..CHANNELS-1 = gain registers; 15 = status register
REG_WDATA  in  GAIN_WIDTH  write data
REG_RDATA  out  GAIN_WIDTH  combinational read of the register at REG_ADDR
OUT_DATA  out  OUT_WIDTH  mixed, saturated sample
OUT_VALID  out  1  one-cycle pulse when OUT_DATA updates
BUSY  out  1  high while a mix is in progress
CLIP  out  1  sticky saturation flag (status bit 0)
OVERRUN  out  1  sticky dropped-strobe flag (status bit 1)

Behaviour:
- Reset: RESET_n is asynchronous and active-low; CLK is the clock. On reset: OUT_DATA=0, OUT_VALID=0, BUSY=0, CLIP=0, OVERRUN=0, all gains=GAIN_RESET, FSM=IDLE, accumulator=0.
- FSM states IDLE -> ACCUM -> SCALE -> IDLE.
- IDLE: when SAMPLE_EN=1, snapshot IN_DATA and all effective gains, clear the accumulator, set ch=0, go to ACCUM, set BUSY=1.
- ACCUM: each cycle, acc += in[ch]*gain[ch] (signed × zero-extended unsigned). After ch=CHANNELS-1, go to SCALE.
  - Accumulator width = IN_WIDTH+GAIN_WIDTH+ceil(log2(CHANNELS))+1; it cannot overflow.
- SCALE: compute r = acc >>> (GAIN_WIDTH-1), an arithmetic shift that truncates toward -inf.
  - If r is outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], clamp to the nearest bound and set CLIP.
  - Register the result into OUT_DATA, pulse OUT_VALID for 1 cycle, clear BUSY, go to IDLE.
- Latency: OUT_VALID is asserted exactly CHANNELS+2 cycles after the SAMPLE_EN cycle. Minimum SAMPLE_EN spacing is CHANNELS+2 cycles.
- SAMPLE_EN while BUSY=1: the strobe is ignored, the current mix is unaffected, OVERRUN is set.
- A SAMPLE_EN arriving in the same cycle as the OUT_VALID pulse is accepted (FSM has returned to IDLE).
- Gain writes:
  - Take effect at the next accepted SAMPLE_EN; a mix in progress uses its snapshot.
  - Writes to addresses CHANNELS..14 are ignored and read back 0.
- Status register (addr 15):
  - Read returns {0.., OVERRUN, CLIP}.
  - Writing 1 to a bit clears it.
  - If a set event and a clear occur in the same cycle, the set wins.
- OUT_DATA holds its last value between OUT_VALID pulses.
- Reset mid-mix aborts immediately; no OUT_VALID is produced.

Optional Feature:
Macro: SOUND_MIXER_NG_FADE_EN.
- Defined:
  - Each gain register holds a target value.
  - A separate effective gain steps ±1 toward its target on every accepted SAMPLE_EN, before the snapshot is taken.
  - Effective gains reset to GAIN_RESET.
  - REG_RDATA returns the target.
  - This produces click-free volume changes.
- Undefined: the effective gain equals the register value immediately, and no fade logic is present.

Test Plan:
1. Defaults CHANNELS=4, gains all 0x80; IN=1000, 2000, -500, 0; SAMPLE_EN -> OUT_VALID 6 cycles later, OUT_DATA=2500, CLIP=0.
2. Gain[0]=0x40 and others 0; IN0=1000 -> 500. Then IN0=-3 -> -2 (truncation toward -inf).
3. All four inputs 20000, gains 0x80 -> OUT_DATA=32767, CLIP=1. All inputs -20000 -> OUT_DATA=-32768. Write 0x01 to addr 15 -> CLIP=0.
4. SAMPLE_EN followed by a second SAMPLE_EN 2 cycles later -> a single OUT_VALID with the first set's result, OVERRUN=1. A SAMPLE_EN in the same cycle as OUT_VALID is accepted.
5. Write gain[1]=0 during ACCUM -> the current result is unchanged and the next sample excludes channel 1. Assert RESET_n low mid-ACCUM -> no OUT_VALID, all outputs 0.
6. With SOUND_MIXER_NG_FADE_EN: target gain[0] 0x80→0x00, IN0=128 constant -> outputs 127, 126, … reaching 0 after 128 samples, monotonic. Without the macro: 0 on the first sample.
